// File: rtl/instr_buffer_pkg.sv
// rtl/instr_buffer_pkg.sv - shared CPU package: fetch-queue entry type, buffer sizing and reset PC
package instr_buffer_pkg;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } ibuf_entry_t;

   localparam int          IBUF_DEPTH    = 8;
   localparam int          IBUF_INFLIGHT = 2;
   localparam logic [31:0] RESET_PC      = 32'h1c00_0000;

endpackage

// File: rtl/instr_buffer.sv
// rtl/instr_buffer.sv - circular fetch queue between IF2 and ID with early stall and branch flush
// Optional zero-latency path through an empty queue: INSTR_BUFFER_BYPASS_EN
module instr_buffer
   import instr_buffer_pkg::*;
#(
   parameter int DEPTH    = IBUF_DEPTH,
   parameter int INFLIGHT = IBUF_INFLIGHT
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        EX_BR,
   input  logic [31:0] pc_IF2,
   input  logic [31:0] instr_IF2,
   input  logic        valid_IF2,
   input  logic        ready_ID,
   output logic [31:0] pc_ID,
   output logic [31:0] instr_ID,
   output logic        valid_ID,
   output logic        stall_full_instr,
   output logic        overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam logic [PW-1:0] STALL_TH = PW'(DEPTH - INFLIGHT);

   logic [PW-1:0] wptr_q, wptr_d;
   logic [PW-1:0] rptr_q, rptr_d;
   logic [PW-1:0] count_q, count_d;
   logic          overflow_q, overflow_d;

   ibuf_entry_t   mem_q [DEPTH];
   ibuf_entry_t   incoming;
   ibuf_entry_t   head;

   logic          empty;
   logic          full;
   logic          push_req;
   logic          push;
   logic          pop;
   logic          bypass;
   logic          wr_en;
   logic          rd_en;

   assign empty    = (wptr_q == rptr_q);
   assign full     = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
   assign incoming = '{pc: pc_IF2, instr: instr_IF2};
   assign push_req = valid_IF2 & ~EX_BR;

`ifdef INSTR_BUFFER_BYPASS_EN
   assign bypass = empty & push_req;
`else
   assign bypass = 1'b0;
`endif

   assign valid_ID = ~empty | bypass;
   assign pop      = valid_ID & ready_ID & ~EX_BR;
   assign push     = push_req & (~full | pop);

   // A bypassed entry taken by ID the same cycle never touches storage.
   assign wr_en = push & ~(bypass & ready_ID);
   assign rd_en = pop & ~empty;

   always_comb begin
      head = '0;
      if (bypass) begin
         head = incoming;
      end else if (!empty) begin
         head = mem_q[rptr_q[AW-1:0]];
      end
   end

   assign pc_ID            = head.pc;
   assign instr_ID         = head.instr;
   assign stall_full_instr = (count_q >= STALL_TH);
   assign overflow         = overflow_q;

   always_comb begin
      wptr_d     = wptr_q;
      rptr_d     = rptr_q;
      count_d    = count_q;
      overflow_d = overflow_q | (push_req & full & ~pop);
      if (EX_BR) begin
         wptr_d  = '0;
         rptr_d  = '0;
         count_d = '0;
      end else begin
         if (wr_en) begin
            wptr_d = wptr_q + PW'(1);
         end
         if (rd_en) begin
            rptr_d = rptr_q + PW'(1);
         end
         count_d = count_q + PW'(wr_en) - PW'(rd_en);
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wptr_q     <= '0;
         rptr_q     <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   // Storage is not reset; only slots between rptr and wptr are ever read.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wptr_q[AW-1:0]] <= incoming;
      end
   end

endmodule
